// File: rtl/drive_current_dac_spi_pkg.sv
// Shared definitions for the drive-current DAC SPI writer: frame layout, command code and FSM states.
package drive_current_dac_spi_pkg;

   localparam int DAC_FRAME_W = 24;
   localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'h3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_TAIL  = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   function automatic logic [DAC_FRAME_W-1:0] make_frame(input logic [3:0] cmd,
                                                         input logic [3:0] addr,
                                                         input logic [15:0] data);
      return {cmd, addr, data};
   endfunction

endpackage

// File: rtl/drive_current_dac_spi_clk_tick.sv
// Divider that pulses tick every CLK_DIV cycles while run is high; restart realigns the phase.
module spi_clk_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic restart,
   input  logic run,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = run && (cnt == LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (restart || !run || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/drive_current_dac_spi.sv
// Writes the latest drive_current code to the external DAC as a 24-bit SPI mode-0 frame,
// coalescing register updates that arrive while a frame is in flight.
module drive_current_dac_spi
   import drive_current_dac_spi_pkg::*;
#(
   parameter int         CLK_DIV    = 4,
   parameter int         CS_HOLD    = 8,
   parameter logic [3:0] DAC_CMD    = DAC_CMD_WRITE_UPDATE,
   parameter logic [3:0] DAC_ADDR   = 4'h0,
   parameter bit         INIT_WRITE = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] drive_current,
   input  logic        drive_current_update,
   input  logic        enable,
   output logic        dac_sclk,
   output logic        dac_csn,
   output logic        dac_mosi,
   output logic        busy,
   output logic        done,
   output logic [15:0] dac_value
);

   localparam int HW = $clog2(CS_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HOLD - 1);

   state_t                 state, state_nxt;
   logic                   pending, pend_loaded;
   logic [15:0]            pend_data, frame_data, frame_nxt, start_data;
   logic [DAC_FRAME_W-1:0] shift_reg, shift_nxt, start_frame;
   logic [4:0]             bit_cnt, bit_nxt;
   logic [HW-1:0]          hold_cnt, hold_nxt;
   logic                   csn_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
   logic [15:0]            value_nxt;
   logic                   start, tick, tick_run, tick_restart;

   // Until the first update after reset, the init frame carries the live input.
   assign start_data  = pend_loaded ? pend_data : drive_current;
   assign start_frame = make_frame(DAC_CMD, DAC_ADDR, start_data);

   assign tick_run     = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_TAIL);
   assign tick_restart = (state_nxt != state);

   spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk     (clk),
      .rstn    (rstn),
      .restart (tick_restart),
      .run     (tick_run),
      .tick    (tick)
   );

   always_comb begin
      state_nxt = state;
      csn_nxt   = dac_csn;
      sclk_nxt  = dac_sclk;
      mosi_nxt  = dac_mosi;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      value_nxt = dac_value;
      bit_nxt   = bit_cnt;
      hold_nxt  = hold_cnt;
      shift_nxt = shift_reg;
      frame_nxt = frame_data;
      start     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pending && enable) begin
               start     = 1'b1;
               shift_nxt = start_frame;
               frame_nxt = start_data;
               csn_nxt   = 1'b0;
               mosi_nxt  = start_frame[DAC_FRAME_W-1];
               busy_nxt  = 1'b1;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               sclk_nxt  = 1'b1;
               bit_nxt   = '0;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Falling edge launches the next bit; the low phase after bit 23 ends the shift.
            if (tick) begin
               if (dac_sclk) begin
                  sclk_nxt  = 1'b0;
                  shift_nxt = {shift_reg[DAC_FRAME_W-2:0], 1'b0};
                  mosi_nxt  = shift_reg[DAC_FRAME_W-2];
               end else if (bit_cnt == 5'd23) begin
                  state_nxt = ST_TAIL;
               end else begin
                  sclk_nxt = 1'b1;
                  bit_nxt  = bit_cnt + 5'd1;
               end
            end
         end
         ST_TAIL: begin
            if (tick) begin
               csn_nxt   = 1'b1;
               done_nxt  = 1'b1;
               mosi_nxt  = 1'b0;
               value_nxt = frame_data;
               hold_nxt  = '0;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               busy_nxt  = 1'b0;
               state_nxt = ST_IDLE;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         dac_csn     <= 1'b1;
         dac_sclk    <= 1'b0;
         dac_mosi    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         dac_value   <= '0;
         bit_cnt     <= '0;
         hold_cnt    <= '0;
         pending     <= INIT_WRITE;
         pend_loaded <= 1'b0;
      end else begin
         state     <= state_nxt;
         dac_csn   <= csn_nxt;
         dac_sclk  <= sclk_nxt;
         dac_mosi  <= mosi_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         dac_value <= value_nxt;
         bit_cnt   <= bit_nxt;
         hold_cnt  <= hold_nxt;
         // A same-cycle update wins over the start clear so the newer value gets its own frame.
         if (drive_current_update) begin
            pending     <= 1'b1;
            pend_loaded <= 1'b1;
         end else if (start) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      shift_reg  <= shift_nxt;
      frame_data <= frame_nxt;
      if (drive_current_update) begin
         pend_data <= drive_current;
      end
   end

endmodule

// File: tb/tb_drive_current_dac_spi.sv
// Bench for drive_current_dac_spi: offset-based waveform model checked every cycle,
// plus decoded-frame expectations for the directed scenarios and a randomized soak.
module tb_drive_current_dac_spi;

   localparam int CD = 4;
   localparam int CH = 8;
   localparam int L  = 50 * CD;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] drive_current = 16'h0000;
   logic        drive_current_update = 1'b0;
   logic        enable = 1'b1;
   logic        dac_sclk, dac_csn, dac_mosi, busy, done;
   logic [15:0] dac_value;

   drive_current_dac_spi #(
      .CLK_DIV(CD), .CS_HOLD(CH), .DAC_CMD(4'h3), .DAC_ADDR(4'h0), .INIT_WRITE(1'b1)
   ) dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .drive_current        (drive_current),
      .drive_current_update (drive_current_update),
      .enable               (enable),
      .dac_sclk             (dac_sclk),
      .dac_csn              (dac_csn),
      .dac_mosi             (dac_mosi),
      .busy                 (busy),
      .done                 (done),
      .dac_value            (dac_value)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endtask

   // Model: m_off is the cycle offset since csn fell (-1 when idle); a frame plus hold spans L+CH cycles.
   int          m_off = -1;
   bit          m_pending = 1'b1;
   bit          m_loaded = 1'b0;
   bit          m_was_idle;
   logic [15:0] m_pend = 16'h0;
   logic [23:0] m_frame = 24'h0;
   logic [15:0] m_value = 16'h0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_off = -1; m_pending = 1'b1; m_loaded = 1'b0; m_value = 16'h0;
      end else begin
         m_was_idle = (m_off < 0);
         if (m_off >= 0) begin
            m_off++;
            if (m_off == L + CH) m_off = -1;
         end
         if (m_was_idle && m_pending && enable) begin
            m_off = 0;
            m_frame = {4'h3, 4'h0, (m_loaded ? m_pend : drive_current)};
            m_pending = 1'b0;
         end
         if (drive_current_update) begin
            m_pend = drive_current; m_pending = 1'b1; m_loaded = 1'b1;
         end
         if (m_off == L) m_value = m_frame[15:0];
      end
   end

   logic e_csn, e_sclk, e_mosi, e_busy, e_done;
   int   idx;
   int   done_cnt = 0;
   int   hi_run = 0;
   int   min_gap = 1000;
   bit   seen_low = 1'b0;

   always @(negedge clk) begin
      e_csn  = !(m_off >= 0 && m_off < L);
      e_sclk = (m_off >= CD) && (m_off < 49 * CD) && ((((m_off - CD) / CD) % 2) == 0);
      e_busy = (m_off >= 0);
      e_done = (m_off == L);
      if (m_off >= 0 && m_off < 48 * CD) begin
         idx = 23 - m_off / (2 * CD);
         e_mosi = m_frame[idx];
      end else begin
         e_mosi = 1'b0;
      end
      chk("csn", {31'd0, dac_csn}, {31'd0, e_csn});
      chk("sclk", {31'd0, dac_sclk}, {31'd0, e_sclk});
      chk("mosi", {31'd0, dac_mosi}, {31'd0, e_mosi});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("dac_value", {16'd0, dac_value}, {16'd0, m_value});
      if (done === 1'b1) done_cnt++;
      if (dac_csn === 1'b1) begin
         hi_run++;
      end else begin
         if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
         seen_low = 1'b1;
         hi_run = 0;
      end
   end

   // SPI decoder: bits captured on sclk rising edges, frame pushed when csn rises.
   int          cyc = 0;
   logic [23:0] mon_acc = 24'h0;
   int          mon_bits = 0;
   int          last_rise = 0;
   bit          have_rise = 1'b0;
   int          sclk_period = 0;
   logic [23:0] frames[$];
   int          fbits[$];

   always @(posedge clk) cyc++;

   always @(posedge dac_sclk) begin
      mon_acc = {mon_acc[22:0], dac_mosi};
      mon_bits++;
      if (have_rise) sclk_period = cyc - last_rise;
      last_rise = cyc;
      have_rise = 1'b1;
   end

   always @(negedge dac_csn) begin
      mon_acc = 24'h0; mon_bits = 0; have_rise = 1'b0;
   end

   always @(posedge dac_csn) begin
      frames.push_back(mon_acc);
      fbits.push_back(mon_bits);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [15:0] v);
      drive_current = v;
      drive_current_update = 1'b1;
      step(1);
      drive_current_update = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (!(m_off < 0 && !m_pending) && n < 5000) begin
         step(1);
         n++;
      end
      chk({nm, "_idle_timeout"}, {31'd0, (n >= 5000)}, 32'd0);
      step(2);
   endtask

   task automatic wait_csn_low(input string nm);
      int n;
      n = 0;
      while (dac_csn !== 1'b0 && n < 50) begin
         step(1);
         n++;
      end
      chk({nm, "_csn_timeout"}, {31'd0, (n >= 50)}, 32'd0);
   endtask

   int low_cnt;
   int nw;

   initial begin
      // Reset state and init frame with drive_current = 0
      step(3);
      chk("rst_csn", {31'd0, dac_csn}, 32'd1);
      chk("rst_sclk", {31'd0, dac_sclk}, 32'd0);
      chk("rst_mosi", {31'd0, dac_mosi}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_value", {16'd0, dac_value}, 32'd0);
      frames.delete(); fbits.delete(); done_cnt = 0;
      rstn = 1'b1;
      wait_idle("t1");
      chk("t1_nframes", frames.size(), 32'd1);
      if (frames.size() >= 1) begin
         chk("t1_frame", {8'd0, frames[0]}, 32'h00300000);
         chk("t1_bits", fbits[0], 32'd24);
      end
      chk("t1_done_cnt", done_cnt, 32'd1);
      chk("t1_value", {16'd0, dac_value}, 32'd0);
      chk("t1_csn_high", {31'd0, dac_csn}, 32'd1);

      // Single update: latency, contents, sclk period
      frames.delete(); fbits.delete(); done_cnt = 0;
      pulse(16'hA5C3);
      chk("t2_csn_n1", {31'd0, dac_csn}, 32'd1);
      step(1);
      chk("t2_csn_n2", {31'd0, dac_csn}, 32'd0);
      wait_idle("t2");
      chk("t2_nframes", frames.size(), 32'd1);
      if (frames.size() >= 1) begin
         chk("t2_frame", {8'd0, frames[0]}, 32'h0030A5C3);
         chk("t2_bits", fbits[0], 32'd24);
      end
      chk("t2_period", sclk_period, 32'd8);
      chk("t2_done_cnt", done_cnt, 32'd1);
      chk("t2_value", {16'd0, dac_value}, 32'h0000A5C3);

      // Three updates during one frame coalesce into one follow-up frame
      frames.delete(); fbits.delete(); done_cnt = 0; min_gap = 1000; seen_low = 1'b0;
      pulse(16'h0100);
      wait_csn_low("t3");
      step(30);
      pulse(16'h0200);
      step(50);
      pulse(16'h0300);
      wait_idle("t3");
      chk("t3_nframes", frames.size(), 32'd2);
      if (frames.size() >= 2) begin
         chk("t3_frame0", {8'd0, frames[0]}, 32'h00300100);
         chk("t3_frame1", {8'd0, frames[1]}, 32'h00300300);
      end
      chk("t3_done_cnt", done_cnt, 32'd2);
      chk("t3_gap_ok", {31'd0, (min_gap >= CH)}, 32'd1);

      // enable low holds the request
      frames.delete(); fbits.delete(); done_cnt = 0;
      enable = 1'b0;
      pulse(16'h1234);
      low_cnt = 0;
      repeat (100) begin
         step(1);
         if (dac_csn !== 1'b1) low_cnt++;
      end
      chk("t4_no_activity", low_cnt, 32'd0);
      enable = 1'b1;
      step(1);
      chk("t4_start", {31'd0, dac_csn}, 32'd0);
      wait_idle("t4");
      chk("t4_nframes", frames.size(), 32'd1);
      if (frames.size() >= 1) chk("t4_frame", {8'd0, frames[0]}, 32'h00301234);

      // Reset mid-frame, then live-sampled init frame
      pulse(16'h5555);
      drive_current = 16'h0077;
      nw = 0;
      while (mon_bits < 10 && nw < 2000) begin
         step(1);
         nw++;
      end
      chk("t5_bit10_timeout", {31'd0, (nw >= 2000)}, 32'd0);
      rstn = 1'b0;
      #1;
      chk("t5_csn", {31'd0, dac_csn}, 32'd1);
      chk("t5_sclk", {31'd0, dac_sclk}, 32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_value", {16'd0, dac_value}, 32'd0);
      step(3);
      frames.delete(); fbits.delete(); done_cnt = 0;
      rstn = 1'b1;
      wait_idle("t5");
      chk("t5_nframes", frames.size(), 32'd1);
      if (frames.size() >= 1) chk("t5_frame", {8'd0, frames[0]}, 32'h00300077);
      chk("t5_value_after", {16'd0, dac_value}, 32'h00000077);

      // Update in the exact cycle the FSM leaves IDLE
      frames.delete(); fbits.delete(); done_cnt = 0;
      enable = 1'b0;
      pulse(16'h1111);
      step(5);
      enable = 1'b1;
      pulse(16'h2222);
      wait_idle("t6");
      chk("t6_nframes", frames.size(), 32'd2);
      if (frames.size() >= 2) begin
         chk("t6_frame0", {8'd0, frames[0]}, 32'h00301111);
         chk("t6_frame1", {8'd0, frames[1]}, 32'h00302222);
      end
      chk("t6_done_cnt", done_cnt, 32'd2);

      // Randomized soak against the cycle model
      repeat (3000) begin
         enable = ($urandom_range(0, 9) != 0);
         drive_current = 16'($urandom);
         drive_current_update = ($urandom_range(0, 39) == 0);
         step(1);
      end
      drive_current_update = 1'b0;
      enable = 1'b1;
      wait_idle("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
